// File: rtl/pe_psum_drain.sv
// Captures the PE psum vector on a done pulse and streams it out one element per beat.
// Optional PSUM_ACCUM_EN: sums ACCUM_ROWS captured rows elementwise before draining.
module pe_psum_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int INPUT_SIZE = 8,
    parameter int ACCUM_ROWS = 3,
    localparam int NUM_PSUM  = INPUT_SIZE - 2,
    localparam int IDX_W     = (NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    pe_done_i,
    input  logic [INPUT_SIZE-3:0][2*DATA_WIDTH-1:0] psum_i,
    output logic                                    m_valid_o,
    input  logic                                    m_ready_i,
    output logic [2*DATA_WIDTH-1:0]                 m_data_o,
    output logic [IDX_W-1:0]                        m_index_o,
    output logic                                    m_last_o,
    output logic                                    busy_o,
    output logic                                    overrun_o
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PSUM - 1);

`ifdef PSUM_ACCUM_EN
    localparam int ROWS_W = $clog2(ACCUM_ROWS + 1);
    localparam logic [ROWS_W-1:0] ROWS_LAST = ROWS_W'(ACCUM_ROWS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    state_t                      w_load_target;
    logic [NUM_PSUM-1:0][PW-1:0] r_buf;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            w_idx_next;
    logic                        r_overrun;
    logic                        w_capture;
    logic                        w_xfer;
    logic                        w_at_last;
    logic                        w_load;
    logic                        w_add;
    logic                        w_overrun_set;
`ifdef PSUM_ACCUM_EN
    logic [ROWS_W-1:0]           r_rows;
`endif

    assign w_capture = en & pe_done_i;
    assign w_xfer    = (r_state == S_DRAIN) & m_ready_i;
    assign w_at_last = (r_idx == IDX_LAST);

    // A fresh load drains directly unless more rows must be accumulated first.
`ifdef PSUM_ACCUM_EN
    assign w_load_target = (ACCUM_ROWS == 1) ? S_DRAIN : S_ACCUM;
`else
    assign w_load_target = S_DRAIN;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, index advance and buffer load/add/overrun decisions.
    always_comb begin
        w_next_state  = r_state;
        w_idx_next    = r_idx;
        w_load        = 1'b0;
        w_add         = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_load       = 1'b1;
                    w_idx_next   = '0;
                    w_next_state = w_load_target;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef PSUM_ACCUM_EN
            S_ACCUM: begin
                if (w_capture) begin
                    w_add = 1'b1;
                    if (r_rows == ROWS_LAST) begin
                        w_next_state = S_DRAIN;
                    end else begin
                        w_next_state = S_ACCUM;
                    end
                end else begin
                    w_next_state = S_ACCUM;
                end
            end
`endif
            S_DRAIN: begin
                if (w_xfer && w_at_last) begin
                    w_idx_next = '0;
                    if (w_capture) begin
                        w_load       = 1'b1;
                        w_next_state = w_load_target;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end else begin
                        w_idx_next = r_idx;
                    end
                    // Capture while a frame is still mid-drain: drop it and flag it.
                    if (w_capture) begin
                        w_overrun_set = 1'b1;
                    end else begin
                        w_overrun_set = 1'b0;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Buffer, beat index, sticky overrun and row counter.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_buf     <= '0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
`ifdef PSUM_ACCUM_EN
            r_rows    <= '0;
`endif
        end else begin
            r_idx <= w_idx_next;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
            if (w_load) begin
                r_buf <= psum_i;
`ifdef PSUM_ACCUM_EN
                r_rows <= ROWS_W'(1);
`endif
            end else if (w_add) begin
                for (int i = 0; i < NUM_PSUM; i++) begin
                    r_buf[i] <= r_buf[i] + psum_i[i];
                end
`ifdef PSUM_ACCUM_EN
                r_rows <= r_rows + ROWS_W'(1);
`endif
            end
        end
    end

    assign m_valid_o = (r_state == S_DRAIN);
    assign m_data_o  = m_valid_o ? r_buf[r_idx] : '0;
    assign m_index_o = r_idx;
    assign m_last_o  = m_valid_o & w_at_last;
    assign busy_o    = (r_state != S_IDLE);
    assign overrun_o = r_overrun;

endmodule
